// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: instruction-fetch PC generator for the IFU.
// Issues sequential fetch requests, remembers the PC of every accepted
// request in order, and buffers returned words with their PCs in a small
// FIFO toward decode. A redirect from the branch unit discards everything
// still in flight and everything buffered.
//
// Handshake semantics (req_* and inst_* ports): a transfer happens on a
// rising clk edge where valid and ready are both 1. Once valid is raised it
// stays high, with its payload unchanged, until that transfer happens; ready
// may toggle freely and never depends on valid. The response port has no
// ready: an issue credit is only spent when buffer space is already
// reserved, so a response can always be absorbed.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] pc_o,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   redir_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_cnt;

    // PCs of accepted requests, oldest at pcq_rd
    logic [31:0]   pcq [DEPTH];
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;

    // Instruction FIFO toward decode
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;

    logic          redirect;
    logic          handshake;
    logic          rsp_keep;
    logic          pop;
    logic [CW-1:0] inflight_nxt;
    logic [31:0]   jump_tgt;
    logic [CW:0]   used;
    logic          unused_addr_bits;

    assign used         = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign req_valid_o  = (state == HOLD) || ((state == RUN) && (used < {1'b0, DEPTH_C}));
    assign pc_o         = pc;
    assign inst_valid_o = (fifo_cnt != '0);
    assign inst_o       = inst_valid_o ? fifo_data[fifo_rd] : '0;
    assign inst_addr_o  = inst_valid_o ? fifo_addr[fifo_rd] : '0;
    assign dbg_state    = state;
    assign unused_addr_bits = ^jump_addr_i[1:0];

    // Per-cycle events; a redirect overrides any response write or FIFO pop
    always_comb begin
        redirect     = jump_flag_i && (state != BOOT);
        handshake    = req_valid_o && req_ready_i;
        rsp_keep     = rsp_valid_i && !redirect && (drop == '0);
        pop          = inst_valid_o && inst_ready_i && !redirect;
        inflight_nxt = inflight + CW'(handshake) - CW'(rsp_valid_i);
        jump_tgt     = {jump_addr_i[31:2], 2'b00};
    end

    // Storage arrays: request PC queue and FIFO payload (no reset needed)
    always_ff @(posedge clk) begin
        if (handshake) begin
            pcq[pcq_wr] <= pc;
        end
        if (rsp_keep) begin
            fifo_data[fifo_wr] <= rsp_data_i;
            fifo_addr[fifo_wr] <= pcq[pcq_rd];
        end
    end

    // Fetch FSM, credit counters and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            redir_pc <= '0;
            inflight <= '0;
            drop     <= '0;
            fifo_cnt <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
        end else begin
            inflight <= inflight_nxt;

            // Everything still in flight after a redirect is stale; a held
            // request accepted in HOLD was issued before the redirect too.
            if (redirect) begin
                drop <= inflight_nxt;
            end else begin
                drop <= drop - CW'(rsp_valid_i && (drop != '0))
                             + CW'(handshake && (state == HOLD));
            end

            if (handshake) begin
                pcq_wr <= pcq_wr + AW'(1);
            end
            if (rsp_valid_i) begin
                pcq_rd <= pcq_rd + AW'(1);
            end

            if (redirect) begin
                fifo_cnt <= '0;
                fifo_wr  <= '0;
                fifo_rd  <= '0;
            end else begin
                if (rsp_keep) begin
                    fifo_wr <= fifo_wr + AW'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + AW'(1);
                end
                fifo_cnt <= fifo_cnt + CW'(rsp_keep) - CW'(pop);
            end

            case (state)
                BOOT: begin
                    if (jump_flag_i) begin
                        pc <= jump_tgt;
                    end
                    state <= RUN;
                end
                RUN: begin
                    if (jump_flag_i) begin
                        // A pending request may not change address: park the target
                        if (req_valid_o && !req_ready_i) begin
                            redir_pc <= jump_tgt;
                            state    <= HOLD;
                        end else begin
                            pc <= jump_tgt;
                        end
                    end else if (handshake) begin
                        pc <= pc + 32'd4;
                    end
                end
                HOLD: begin
                    if (jump_flag_i) begin
                        redir_pc <= jump_tgt;
                    end
                    if (handshake) begin
                        pc    <= jump_flag_i ? jump_tgt : redir_pc;
                        state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Credit accounting must keep these unreachable
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && !pop && (fifo_cnt == DEPTH_C)));
    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        !(rsp_valid_i && (inflight == '0)));

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Testbench for ifu_fetch_ctrl: directed steps driving a 1-cycle memory
// model, with a scoreboard of expected {data, pc} words toward decode.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] pc_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [1:0]  dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    ifu_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .pc_o         (pc_o),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_data_i   (rsp_data_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    logic [63:0] exp_q[$];       // {data, pc} expected at decode
    logic [32:0] mem_q[$];       // {stale, pc} accepted, awaiting response
    logic        mem_on = 1'b0;
    logic        pend_stale = 1'b0;
    logic        last_push = 1'b0;
    logic        last_jump = 1'b0;
    logic [31:0] exp_pc = RESET_PC;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Called at a negedge with inputs set; samples, models, then advances.
    task automatic tick();
        logic [32:0] m;
        logic [63:0] e;
        logic        hs;
        logic        st;
        if (last_push) chk("rsp_to_inst_latency", {31'b0, inst_valid_o}, 32'd1);
        if (last_jump) chk("flush_empty", {31'b0, inst_valid_o}, 32'd0);
        last_push = 1'b0;
        last_jump = jump_flag_i;

        // decode side pop
        if (inst_valid_o && inst_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("inst_unexpected", {31'b0, inst_valid_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("inst_addr", inst_addr_o, e[31:0]);
                chk("inst_data", inst_o, e[63:32]);
            end
        end

        // memory response, one cycle after acceptance
        rsp_valid_i = 1'b0;
        rsp_data_i  = '0;
        if (mem_on && mem_q.size() > 0) begin
            m = mem_q.pop_front();
            rsp_valid_i = 1'b1;
            rsp_data_i  = $urandom;
            if (!m[32] && !jump_flag_i) begin
                exp_q.push_back({rsp_data_i, m[31:0]});
                last_push = 1'b1;
            end
        end

        // request side
        hs = req_valid_o && req_ready_i;
        if (hs) begin
            hs_cnt++;
            st = jump_flag_i || pend_stale;
            if (!st) begin
                chk("req_pc", pc_o, exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            mem_q.push_back({st, pc_o});
            pend_stale = 1'b0;
        end else if (req_valid_o && jump_flag_i) begin
            pend_stale = 1'b1;
        end

        // redirect: everything outstanding and buffered is stale
        if (jump_flag_i) begin
            foreach (mem_q[i]) mem_q[i][32] = 1'b1;
            exp_q.delete();
            exp_pc = {jump_addr_i[31:2], 2'b00};
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic jump_tick(input logic [31:0] a);
        jump_flag_i = 1'b1;
        jump_addr_i = a;
        tick();
        jump_flag_i = 1'b0;
        jump_addr_i = '0;
    endtask

    task automatic drain();
        int n;
        req_ready_i  = 1'b0;
        inst_ready_i = 1'b1;
        mem_on       = 1'b1;
        n = 0;
        while ((mem_q.size() != 0 || exp_q.size() != 0 || inst_valid_o) && n < 40) begin
            tick();
            n++;
        end
        chk("drain_fifo_empty", {31'b0, inst_valid_o}, 32'd0);
        chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int h0;
        int n;
        rst = 1'b1; jump_flag_i = 1'b0; jump_addr_i = '0; req_ready_i = 1'b0;
        rsp_valid_i = 1'b0; rsp_data_i = '0; inst_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'b0, req_valid_o}, 32'd0);
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_inst_addr", inst_addr_o, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
        rst = 1'b0;

        // 1: sequential stream, 1-cycle memory, decode always ready
        req_ready_i = 1'b1; inst_ready_i = 1'b1; mem_on = 1'b1;
        chk("boot_no_req", {31'b0, req_valid_o}, 32'd0);
        tick();
        chk("run_req_valid", {31'b0, req_valid_o}, 32'd1);
        chk("run_first_pc", pc_o, RESET_PC);
        h0 = hs_cnt;
        repeat (12) tick();
        chk("stream_reqs", 32'(hs_cnt - h0), 32'd12);
        drain();

        // 2: decode stalled -> credit limits issue to DEPTH
        inst_ready_i = 1'b0; req_ready_i = 1'b1; mem_on = 1'b1;
        h0 = hs_cnt;
        repeat (10) tick();
        chk("credit_fill_reqs", 32'(hs_cnt - h0), 32'd4);
        chk("credit_valid_low", {31'b0, req_valid_o}, 32'd0);
        chk("credit_fifo_full", {31'b0, inst_valid_o}, 32'd1);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        h0 = hs_cnt;
        repeat (6) tick();
        chk("credit_one_more", 32'(hs_cnt - h0), 32'd1);
        chk("credit_valid_low2", {31'b0, req_valid_o}, 32'd0);
        drain();

        // 3: two requests in flight, redirect to 0x100
        req_ready_i = 1'b1; inst_ready_i = 1'b1; mem_on = 1'b0;
        h0 = hs_cnt;
        tick(); tick();
        chk("t3_two_inflight", 32'(hs_cnt - h0), 32'd2);
        jump_tick(32'h0000_0100);
        mem_on = 1'b1;
        n = 0;
        while (!inst_valid_o && n < 20) begin tick(); n++; end
        chk("t3_first_addr", inst_addr_o, 32'h0000_0100);
        repeat (4) tick();
        drain();

        // 4: redirect while a request is held unaccepted
        req_ready_i = 1'b1; inst_ready_i = 1'b1; mem_on = 1'b1;
        jump_tick(32'h0000_0010);
        n = 0;
        while (!(req_valid_o && pc_o == 32'h20) && n < 20) begin tick(); n++; end
        req_ready_i = 1'b0;
        chk("t4_held_pc", pc_o, 32'h0000_0020);
        jump_tick(32'h0000_0200);
        chk("t4_pc_after_j1", pc_o, 32'h0000_0020);
        chk("t4_valid_after_j1", {31'b0, req_valid_o}, 32'd1);
        chk("t4_state_hold", {30'b0, dbg_state}, 32'd2);
        jump_tick(32'h0000_0300);
        chk("t4_pc_after_j2", pc_o, 32'h0000_0020);
        chk("t4_valid_after_j2", {31'b0, req_valid_o}, 32'd1);
        tick();
        chk("t4_pc_still_held", pc_o, 32'h0000_0020);
        req_ready_i = 1'b1;
        tick();
        chk("t4_next_pc", pc_o, 32'h0000_0300);
        chk("t4_state_run", {30'b0, dbg_state}, 32'd1);
        repeat (6) tick();
        drain();

        // 5: redirect in the same cycle as a response and a handshake
        req_ready_i = 1'b1; inst_ready_i = 1'b1; mem_on = 1'b1;
        repeat (4) tick();
        chk("t5_pre_valid", {31'b0, req_valid_o}, 32'd1);
        chk("t5_pre_rsp_pending", {31'b0, mem_q.size() > 0}, 32'd1);
        jump_tick(32'h0000_0400);
        chk("t5_pc", pc_o, 32'h0000_0400);
        repeat (8) tick();
        drain();

        // 6: unaligned target, then reset with requests in flight
        req_ready_i = 1'b1; inst_ready_i = 1'b1; mem_on = 1'b1;
        jump_tick(32'h0000_0103);
        chk("t6_align", pc_o, 32'h0000_0100);
        repeat (4) tick();
        drain();
        req_ready_i = 1'b1; mem_on = 1'b0;
        h0 = hs_cnt;
        repeat (3) tick();
        chk("t6_three_inflight", 32'(hs_cnt - h0), 32'd3);
        rst = 1'b1; req_ready_i = 1'b0; inst_ready_i = 1'b0;
        tick();
        chk("t6_rst_req_valid", {31'b0, req_valid_o}, 32'd0);
        chk("t6_rst_pc", pc_o, RESET_PC);
        chk("t6_rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("t6_rst_inst", inst_o, 32'd0);
        chk("t6_rst_inst_addr", inst_addr_o, 32'd0);
        chk("t6_rst_state", {30'b0, dbg_state}, 32'd0);
        mem_q.delete();
        exp_q.delete();
        pend_stale = 1'b0; last_push = 1'b0; last_jump = 1'b0;
        exp_pc = RESET_PC;
        rst = 1'b0;
        req_ready_i = 1'b1; inst_ready_i = 1'b1; mem_on = 1'b1;
        h0 = hs_cnt;
        repeat (8) tick();
        chk("t6_restart_reqs", 32'(hs_cnt - h0), 32'd7);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
